// File: rtl/chien_consts_pkg.sv
// Shared constants, types and helpers for the Chien-search scheduling slice.
package chien_consts_pkg;
  localparam int W      = 10;
  localparam int T      = 11;
  localparam int P      = 32;
  localparam int N      = 1023;
  localparam int CW_N   = 544;
  localparam int POS_W  = $clog2(N);
  localparam int LOC_W  = 10;
  localparam int POST   = 2;
  localparam int WD_CYC = 64;
  localparam int ARM_WAIT = 4;
  localparam int CNT_W  = $clog2(T+1);
  localparam int CYC_W  = $clog2(WD_CYC+1);

  typedef logic [T:0][W-1:0]         sigma_t;
  typedef logic [T-1:0][LOC_W-1:0]   loc_list_t;
  typedef logic [P-1:0]              hit_mask_t;
  typedef logic [P-1:0][POS_W-1:0]   pos_bus_t;

  typedef enum logic [2:0] {IDLE, LAUNCH, ARM, SCAN, DRAIN, DONE} chien_sched_state_e;

  // Highest nonzero coefficient index; the constant term never raises the degree.
  function automatic logic [CNT_W-1:0] sigma_deg(sigma_t s);
    logic [CNT_W-1:0] d;
    d = '0;
    for (int i = 1; i <= T; i++)
      if (s[i] != '0) d = CNT_W'(i);
    return d;
  endfunction
endpackage

// File: rtl/chien_sched_if.sv
// Sigma intake, chien_search control/stream and Forney-facing result bundle.
interface chien_sched_if import chien_consts_pkg::*; ();
  sigma_t             sig_i;
  logic               sig_valid_i;
  logic               sig_ready_o;
  sigma_t             cs_sigma_o;
  logic               cs_start_o;
  logic               busy_i;
  hit_mask_t          hit_mask_i;
  pos_bus_t           pos_bus_i;
  logic               loc_valid_o;
  logic               loc_ready_i;
  logic [CNT_W-1:0]   loc_cnt_o;
  loc_list_t          loc_pos_o;
  logic               fail_o;
  logic               tmo_o;

  modport slave (
    input  sig_i, sig_valid_i, busy_i, hit_mask_i, pos_bus_i, loc_ready_i,
    output sig_ready_o, cs_sigma_o, cs_start_o, loc_valid_o, loc_cnt_o, loc_pos_o, fail_o, tmo_o
  );
  modport master (
    output sig_i, sig_valid_i, busy_i, hit_mask_i, pos_bus_i, loc_ready_i,
    input  sig_ready_o, cs_sigma_o, cs_start_o, loc_valid_o, loc_cnt_o, loc_pos_o, fail_o, tmo_o
  );
endinterface

// File: rtl/chien_hit_compact.sv
// Filters one cycle of lane hits, drops duplicates and appends them to the location list.
module chien_hit_compact
  import chien_consts_pkg::*;
(
  input  loc_list_t        list_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  hit_mask_t        hit_mask_i,
  input  pos_bus_t         pos_bus_i,
  output loc_list_t        list_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);
  logic [LOC_W-1:0] pos;
  logic             dup;

  // Lanes are folded in ascending order so earlier lanes land first and later
  // lanes see their entries when checking for duplicates.
  always_comb begin
    list_o = list_i;
    cnt_o  = cnt_i;
    ovf_o  = 1'b0;
    pos    = '0;
    dup    = 1'b0;
    for (int t = 0; t < P; t++) begin
      pos = LOC_W'(pos_bus_i[t]);
      dup = 1'b0;
      for (int k = 0; k < T; k++)
        if (CNT_W'(k) < cnt_o && list_o[k] == pos) dup = 1'b1;
      if (hit_mask_i[t] && pos_bus_i[t] < POS_W'(CW_N) && !dup) begin
        if (cnt_o == CNT_W'(T)) begin
          ovf_o = 1'b1;
        end else begin
          for (int k = 0; k < T; k++)
            if (CNT_W'(k) == cnt_o) list_o[k] = pos;
          cnt_o = cnt_o + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/chien_sched.sv
// Launches chien_search for one sigma, follows its busy window plus drain, and
// reports the compacted root list with a decode-failure verdict.
module chien_sched
  import chien_consts_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  chien_sched_if.slave bus
);
  chien_sched_state_e state, state_n;
  logic [CYC_W-1:0]   cyc;
  logic [CNT_W-1:0]   deg_in, deg, cnt, cnt_nx;
  loc_list_t          list, list_nx;
  sigma_t             sigma_q;
  logic               ovf, ovf_nx, tmo, bad0, acc, cap_en, tmo_set;

  assign deg_in = sigma_deg(bus.sig_i);
  assign acc    = bus.sig_valid_i && (state == IDLE);

  always_comb begin
    state_n = state;
    cap_en  = 1'b0;
    tmo_set = 1'b0;
    unique case (state)
      IDLE:   if (bus.sig_valid_i) state_n = (deg_in == '0) ? DONE : LAUNCH;
      LAUNCH: state_n = ARM;
      ARM: begin
        cap_en = 1'b1;
        if (bus.busy_i) state_n = SCAN;
        else if (cyc == CYC_W'(ARM_WAIT-1)) begin
          state_n = DONE;
          tmo_set = 1'b1;
        end
      end
      SCAN: begin
        cap_en = 1'b1;
        if (!bus.busy_i) state_n = DRAIN;
        else if (cyc == CYC_W'(WD_CYC-1)) begin
          state_n = DONE;
          tmo_set = 1'b1;
        end
      end
      DRAIN: begin
        cap_en = 1'b1;
        if (cyc == CYC_W'(POST-1)) state_n = DONE;
      end
      DONE:    if (bus.loc_ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;
  end

  chien_hit_compact u_compact (
    .list_i     (list),
    .cnt_i      (cnt),
    .hit_mask_i (bus.hit_mask_i),
    .pos_bus_i  (bus.pos_bus_i),
    .list_o     (list_nx),
    .cnt_o      (cnt_nx),
    .ovf_o      (ovf_nx)
  );

  // cyc restarts on every state change, so it times ARM, SCAN and DRAIN alike.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cyc     <= '0;
      sigma_q <= '0;
      deg     <= '0;
      list    <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      tmo     <= 1'b0;
      bad0    <= 1'b0;
    end else begin
      cyc <= (state_n != state) ? '0 : cyc + CYC_W'(1);
      if (acc) begin
        sigma_q <= bus.sig_i;
        deg     <= deg_in;
        list    <= '0;
        cnt     <= '0;
        ovf     <= 1'b0;
        tmo     <= 1'b0;
        bad0    <= (deg_in == '0) && (bus.sig_i[0] == '0);
      end else if (cap_en) begin
        list <= list_nx;
        cnt  <= cnt_nx;
        ovf  <= ovf | ovf_nx;
      end
      if (tmo_set) tmo <= 1'b1;
    end
  end

  assign bus.sig_ready_o = (state == IDLE);
  assign bus.cs_start_o  = (state == LAUNCH);
  assign bus.cs_sigma_o  = sigma_q;
  assign bus.loc_valid_o = (state == DONE);
  assign bus.loc_cnt_o   = cnt;
  assign bus.loc_pos_o   = list;
  assign bus.fail_o      = (state == DONE) && (ovf || tmo || bad0 || (cnt != deg));
  assign bus.tmo_o       = (state == DONE) && tmo;
endmodule

// File: tb/tb_chien_sched.sv
// Directed table plus randomized transactions against a stubbed chien_search.
module tb_chien_sched;
  import chien_consts_pkg::*;

  localparam int MAXJ = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chien_sched_if bus();
  chien_sched dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Stub schedule, indexed by negedges after the handshake (j=0 is the start pulse).
  logic      busy_tab [MAXJ];
  hit_mask_t hm_tab   [MAXJ];
  pos_bus_t  pb_tab   [MAXJ];

  typedef struct {
    sigma_t sig; int bs; int blen; int nh;
    logic [3:0][7:0] hj; logic [3:0][4:0] hl; logic [3:0][9:0] hp;
    int bn; int bj; int bp0;
    int e_jd; int e_cnt; loc_list_t e_pos; int np; logic e_fail; logic e_tmo; int hold;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic sigma_t mk_sig(int d, logic c0);
    sigma_t s = '0;
    if (c0) s[0] = W'($urandom_range(1, 1023));
    for (int i = 1; i < d; i++) s[i] = W'($urandom_range(0, 1023));
    if (d > 0) s[d] = W'($urandom_range(1, 1023));
    return s;
  endfunction

  function automatic vec_t vrow(sigma_t s, int bs, int blen, int jd, int cnt, logic f, logic t, int hold);
    vec_t v;
    v.sig = s; v.bs = bs; v.blen = blen; v.nh = 0;
    v.hj = '0; v.hl = '0; v.hp = '0; v.bn = 0; v.bj = 0; v.bp0 = 0;
    v.e_jd = jd; v.e_cnt = cnt; v.e_pos = '0; v.np = 0; v.e_fail = f; v.e_tmo = t; v.hold = hold;
    return v;
  endfunction

  function automatic vec_t rh(vec_t v, int j, int l, int p);
    v.hj[v.nh] = 8'(j); v.hl[v.nh] = 5'(l); v.hp[v.nh] = 10'(p); v.nh++;
    return v;
  endfunction

  function automatic vec_t re(vec_t v, int p);
    v.e_pos[v.np] = 10'(p); v.np++;
    return v;
  endfunction

  task automatic clr_tab();
    for (int j = 0; j < MAXJ; j++) begin
      busy_tab[j] = 1'b0;
      hm_tab[j]   = '0;
      for (int l = 0; l < P; l++) pb_tab[j][l] = POS_W'($urandom_range(0, 1023));
    end
  endtask

  task automatic set_busy(input int bs, input int blen);
    if (bs > 0)
      for (int j = bs; j < bs + blen && j < MAXJ; j++) busy_tab[j] = 1'b1;
  endtask

  task automatic add_hit(input int j, input int l, input int p);
    hm_tab[j][l] = 1'b1;
    pb_tab[j][l] = POS_W'(p);
  endtask

  // Reference: finish time from the busy schedule by arithmetic, then a queue of
  // distinct in-range positions seen over the capture window.
  task automatic model(input sigma_t s, input int bs, input int blen,
                       output int e_jd, output int e_cnt, output loc_list_t e_pos,
                       output logic e_fail, output logic e_tmo);
    int d;
    int q[$];
    logic ovf, found;
    d = 0;
    for (int i = 1; i <= T; i++) if (s[i] != '0) d = i;
    e_tmo = 1'b0; e_pos = '0; ovf = 1'b0;
    if (d == 0) begin
      e_jd = 0; e_cnt = 0; e_fail = (s[0] == '0);
      return;
    end
    if (bs < 1 || bs > ARM_WAIT) begin e_jd = ARM_WAIT + 1; e_tmo = 1'b1; end
    else if (blen - 1 >= WD_CYC) begin e_jd = bs + WD_CYC + 1; e_tmo = 1'b1; end
    else e_jd = bs + blen + 1 + POST;
    for (int j = 1; j < e_jd; j++)
      for (int l = 0; l < P; l++)
        if (hm_tab[j][l] && int'(pb_tab[j][l]) < CW_N) begin
          found = 1'b0;
          foreach (q[i]) if (q[i] == int'(pb_tab[j][l])) found = 1'b1;
          if (!found) begin
            if (q.size() == T) ovf = 1'b1;
            else q.push_back(int'(pb_tab[j][l]));
          end
        end
    e_cnt = q.size();
    foreach (q[i]) e_pos[i] = LOC_W'(q[i]);
    e_fail = ovf | e_tmo | (e_cnt != d);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " sig_ready"}, 128'(bus.sig_ready_o), 128'(1));
    chk({tag, " cs_start"},  128'(bus.cs_start_o),  128'(0));
    chk({tag, " cs_sigma"},  128'(bus.cs_sigma_o),  128'(0));
    chk({tag, " loc_valid"}, 128'(bus.loc_valid_o), 128'(0));
    chk({tag, " loc_cnt"},   128'(bus.loc_cnt_o),   128'(0));
    chk({tag, " loc_pos"},   128'(bus.loc_pos_o),   128'(0));
    chk({tag, " fail"},      128'(bus.fail_o),      128'(0));
    chk({tag, " tmo"},       128'(bus.tmo_o),       128'(0));
  endtask

  task automatic run_txn(input string tag, input sigma_t s, input int e_jd, input int e_cnt,
                         input loc_list_t e_pos, input logic e_fail, input logic e_tmo, input int hold);
    int jd, starts;
    logic ctl_bad, unstable;
    logic [CNT_W-1:0] snap_cnt;
    loc_list_t snap_pos;
    logic snap_fail, snap_tmo;
    @(negedge clk);
    bus.sig_i = s; bus.sig_valid_i = 1'b1; bus.loc_ready_i = 1'b0;
    chk({tag, " ready_idle"}, 128'(bus.sig_ready_o), 128'(1));
    @(negedge clk);
    bus.sig_valid_i = 1'b0;
    chk({tag, " cs_sigma"}, 128'(bus.cs_sigma_o), 128'(s));
    jd = -1; starts = 0; ctl_bad = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus.cs_start_o) begin starts++; if (k != 0) ctl_bad = 1'b1; end
      if (bus.sig_ready_o) ctl_bad = 1'b1;
      if (bus.loc_valid_o) begin jd = k; break; end
      bus.busy_i     = (k < MAXJ) ? busy_tab[k] : 1'b0;
      bus.hit_mask_i = (k < MAXJ) ? hm_tab[k] : '0;
      bus.pos_bus_i  = (k < MAXJ) ? pb_tab[k] : '0;
      @(negedge clk);
    end
    bus.busy_i = 1'b0; bus.hit_mask_i = '0;
    chk({tag, " latency"}, 128'(jd), 128'(e_jd));
    chk({tag, " starts"}, 128'(starts), 128'((e_jd > 0) ? 1 : 0));
    chk({tag, " ctl"}, 128'(ctl_bad), 128'(0));
    if (jd < 0) begin
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      return;
    end
    chk({tag, " cnt"},  128'(bus.loc_cnt_o), 128'(e_cnt));
    chk({tag, " pos"},  128'(bus.loc_pos_o), 128'(e_pos));
    chk({tag, " fail"}, 128'(bus.fail_o),    128'(e_fail));
    chk({tag, " tmo"},  128'(bus.tmo_o),     128'(e_tmo));
    snap_cnt = bus.loc_cnt_o; snap_pos = bus.loc_pos_o; snap_fail = bus.fail_o; snap_tmo = bus.tmo_o;
    unstable = 1'b0;
    for (int h = 0; h < hold; h++) begin
      bus.sig_i = mk_sig(3, 1'b1); bus.sig_valid_i = 1'b1;
      @(negedge clk);
      if (!bus.loc_valid_o || bus.sig_ready_o || bus.loc_cnt_o != snap_cnt ||
          bus.loc_pos_o != snap_pos || bus.fail_o != snap_fail || bus.tmo_o != snap_tmo)
        unstable = 1'b1;
    end
    if (hold > 0) chk({tag, " hold_stable"}, 128'(unstable), 128'(0));
    bus.sig_valid_i = 1'b0; bus.loc_ready_i = 1'b1;
    @(negedge clk);
    chk({tag, " release_valid"}, 128'(bus.loc_valid_o), 128'(0));
    chk({tag, " release_ready"}, 128'(bus.sig_ready_o), 128'(1));
    bus.loc_ready_i = 1'b0;
  endtask

  vec_t vt[12];

  initial begin
    sigma_t one, s;
    int bs, blen, jmax, nh, e_jd, e_cnt;
    loc_list_t e_pos;
    logic e_fail, e_tmo, lv_seen;

    one = '0; one[0] = W'(1);
    vt[0]  = re(re(rh(rh(vrow(mk_sig(2, 1'b1), 2, 18, 23, 2, 1'b0, 1'b0, 10), 10, 4, 300), 15, 20, 5), 300), 5);
    vt[1]  = vrow(one, 0, 0, 0, 0, 1'b0, 1'b0, 1);
    vt[2]  = vrow('0, 0, 0, 0, 0, 1'b1, 1'b0, 0);
    vt[3]  = re(re(re(rh(rh(rh(vrow(mk_sig(3, 1'b1), 1, 10, 14, 3, 1'b0, 1'b0, 0),
               10, 3, 100), 10, 17, 200), 11, 9, 7), 100), 200), 7);
    vt[4]  = vrow(mk_sig(11, 1'b1), 1, 5, 9, 11, 1'b1, 1'b0, 0);
    vt[4].bn = 12; vt[4].bj = 3; vt[4].bp0 = 10;
    for (int i = 0; i < T; i++) vt[4] = re(vt[4], 10 + 3*i);
    vt[5]  = re(rh(rh(rh(rh(vrow(mk_sig(1, 1'b1), 1, 6, 10, 1, 1'b0, 1'b0, 0),
               2, 0, 40), 2, 2, 600), 2, 5, 40), 4, 1, 40), 40);
    vt[6]  = vrow(mk_sig(2, 1'b1), 1, 70, 66, 0, 1'b1, 1'b1, 0);
    vt[7]  = re(rh(vrow(mk_sig(2, 1'b1), 0, 0, 5, 1, 1'b1, 1'b1, 0), 3, 6, 50), 50);
    vt[8]  = re(rh(rh(vrow(mk_sig(2, 1'b1), 4, 8, 15, 1, 1'b1, 1'b0, 0), 5, 31, 543), 5, 30, 544), 543);
    vt[9]  = vrow(mk_sig(1, 1'b1), 5, 10, 5, 0, 1'b1, 1'b1, 0);
    vt[10] = re(rh(vrow(mk_sig(1, 1'b1), 1, 64, 68, 1, 1'b0, 1'b0, 0), 66, 0, 1), 1);
    vt[11] = vrow(mk_sig(1, 1'b1), 1, 65, 66, 0, 1'b1, 1'b1, 0);

    bus.sig_i = '0; bus.sig_valid_i = 1'b0; bus.busy_i = 1'b0;
    bus.hit_mask_i = '0; bus.pos_bus_i = '0; bus.loc_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      clr_tab();
      set_busy(vt[i].bs, vt[i].blen);
      for (int h = 0; h < vt[i].nh; h++) add_hit(int'(vt[i].hj[h]), int'(vt[i].hl[h]), int'(vt[i].hp[h]));
      for (int b = 0; b < vt[i].bn; b++) add_hit(vt[i].bj, b, vt[i].bp0 + 3*b);
      run_txn($sformatf("vec%0d", i), vt[i].sig, vt[i].e_jd, vt[i].e_cnt, vt[i].e_pos,
              vt[i].e_fail, vt[i].e_tmo, vt[i].hold);
    end

    // Reset in the middle of SCAN must abandon the transaction silently.
    clr_tab(); set_busy(1, 30); add_hit(3, 2, 77);
    @(negedge clk);
    bus.sig_i = mk_sig(2, 1'b1); bus.sig_valid_i = 1'b1;
    @(negedge clk);
    bus.sig_valid_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.busy_i = busy_tab[k]; bus.hit_mask_i = hm_tab[k]; bus.pos_bus_i = pb_tab[k];
      @(negedge clk);
    end
    chk("rst pre_cnt", 128'(bus.loc_cnt_o), 128'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("rst_scan");
    rst_n = 1'b1; bus.busy_i = 1'b0; bus.hit_mask_i = '0;
    lv_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.loc_valid_o || !bus.sig_ready_o) lv_seen = 1'b1;
    end
    chk("rst post_idle", 128'(lv_seen), 128'(0));

    for (int r = 0; r < 40; r++) begin
      clr_tab();
      s = mk_sig($urandom_range(0, 11), ($urandom_range(0, 3) != 0));
      bs = $urandom_range(1, 5);
      blen = ($urandom_range(0, 9) < 8) ? $urandom_range(1, 24) : 62 + $urandom_range(0, 4);
      jmax = (bs + blen + 4 > 80) ? 80 : bs + blen + 4;
      nh = $urandom_range(0, 14);
      for (int h = 0; h < nh; h++)
        add_hit($urandom_range(0, jmax), $urandom_range(0, P-1),
                ($urandom_range(0, 1) != 0) ? 37 * $urandom_range(0, 15) : $urandom_range(0, 700));
      set_busy(bs, blen);
      model(s, bs, blen, e_jd, e_cnt, e_pos, e_fail, e_tmo);
      run_txn($sformatf("rnd%0d", r), s, e_jd, e_cnt, e_pos, e_fail, e_tmo, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/chien_sched.md
Name: chien_sched

Overview:
- Controller between the RiBM key-equation stage and chien_search.
- Accepts a sigma polynomial (low-first) through a valid/ready handshake, computes its degree, and launches chien_search.
- Follows the busy window plus a fixed post-drain and compacts the per-lane hit_mask/pos_bus stream into an ordered error-location list.
- Presents the list to Forney with a decoding-failure verdict: root count must equal deg(sigma), be at most T, with no timeout.

Parameters:
- W, 10, GF(2^W) symbol width
- T, 11, correction capability (max sigma degree)
- P, 32, chien_search lane parallelism
- N, 1023, multiplicative group order
- n, 544, codeword length
- POST, 2, cycles sampled after busy_i falls
- WD_CYC, 64, watchdog limit on cycles in SCAN (must exceed ceil(n/P)+2 = 19)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- sig_i  in  (T+1)×W  sigma coefficients, index 0 = constant term
- sig_valid_i  in  1  sigma offered
- sig_ready_o  out  1  controller idle, accepts sigma
- cs_sigma_o  out  (T+1)×W  registered sigma to chien_search.sigma_low_i
- cs_start_o  out  1  one-cycle pulse to chien_search start_i and sigma_valid_i
- busy_i  in  1  chien_search.busy_o
- hit_mask_i  in  P  chien_search.hit_mask_o
- pos_bus_i  in  P×clog2(N)  chien_search.pos_bus_o (codeword index)
- loc_valid_o  out  1  result list valid
- loc_ready_i  in  1  downstream accepts result
- loc_cnt_o  out  4  number of stored locations (0..T)
- loc_pos_o  out  T×10  locations in capture order; unused entries are 0
- fail_o  out  1  uncorrectable: count≠deg, overflow, or timeout
- tmo_o  out  1  watchdog fired (subset of fail_o)

Behaviour:
- Reset (rst_ni=0 at posedge):
  - state=IDLE; sig_ready_o=1; cs_start_o=0; cs_sigma_o=0.
  - loc_valid_o=0, loc_cnt_o=0, loc_pos_o=0, fail_o=0, tmo_o=0.
  - Reset mid-operation aborts immediately; no output is produced.
- IDLE:
  - sig_ready_o=1.
  - On sig_valid_i&&sig_ready_o: latch sig_i into cs_sigma_o; deg = highest nonzero index (0 if all of 1..T are zero); clear list and counters.
  - deg==0 → DONE directly, cnt=0, fail=(sig_i[0]==0). No launch.
  - Otherwise → LAUNCH.
- LAUNCH: cs_start_o=1 for exactly this one cycle → ARM.
- ARM:
  - Wait for busy_i=1; the capture slice is active in this state.
  - If busy_i is not seen within 4 cycles → DONE with tmo_o=1, fail_o=1.
- SCAN:
  - Capture every cycle while busy_i=1; count cycles.
  - busy_i falls → DRAIN. Count reaching WD_CYC → DONE with tmo_o=1, fail_o=1.
- DRAIN: capture for POST more cycles → DONE.
- Capture rule, applied each cycle in ARM/SCAN/DRAIN:
  - Scan lanes 0..P-1 ascending.
  - A lane is accepted when hit_mask_i[t]=1, pos_bus_i[t]<n, and the position is not already in the list (dedup).
  - Accepted positions are appended in lane order; multiple appends per cycle are allowed.
  - When cnt==T, further accepted hits set ovf=1 and are dropped.
- DONE:
  - loc_valid_o=1 with fail_o = ovf | tmo | (cnt≠deg).
  - Outputs hold stable until loc_valid_o&&loc_ready_i, then → IDLE with loc_valid_o=0 on the next cycle.
  - sig_ready_o=0 in every state except IDLE. A sig_valid_i arriving in DONE waits.
- Latency:
  - sig handshake to cs_start_o: 1 cycle.
  - busy fall to loc_valid_o: POST+1 cycles.
  - deg==0 bypass: loc_valid_o on the cycle after the handshake.
- Width rules: pos stored as 10 bits (n-1=543 fits); cnt saturates at T.

Decomposition:
- Package chien_consts_pkg, extended with:
  - state enum chien_sched_state_e {IDLE, LAUNCH, ARM, SCAN, DRAIN, DONE};
  - localparams POST, WD_CYC, CNT_W=$clog2(T+1);
  - sigma array typedef.
- One sub-module, chien_hit_compact: combinational P-lane filter, dedup and append into the T-entry list. Inputs are the current list and cnt; outputs are the next list, next cnt and the ovf flag.

Test Plan:
- Sigma for errors at cw_idx 5 and 300 (deg=2), loc_ready_i=1 → one cs_start_o pulse; loc_valid_o with cnt=2, pos={300,5} or lane-order equivalent, fail_o=0.
- sig_i = {1,0,…,0} → no cs_start_o; loc_valid_o one cycle after handshake, cnt=0, fail_o=0. sig_i all zero → fail_o=1.
- Stubbed chien asserts lanes 3 and 17 in the last busy cycle and lane 9 one cycle after the fall, deg=3 → cnt=3, fail_o=0. Confirms the POST window captures late hits.
- Stub reports 12 distinct hits with deg=11 → cnt=11, fail_o=1 (ovf). Stub repeats pos 40 twice → stored once.
- Stub holds busy_i high for 70 cycles → DONE at cycle 64 of SCAN, tmo_o=1, fail_o=1. Stub never raises busy_i → tmo after 4 ARM cycles.
- loc_ready_i held 0 for 10 cycles with a new sig_valid_i pending → outputs stable, sig_ready_o=0. rst_ni=0 during SCAN → all outputs at reset values the next cycle, no loc_valid_o.
